// File: rtl/dual_port_ram_param.sv
// Parametrised simple dual-port RAM with a clear sweep after reset, a read-valid strobe,
// a selectable read-during-write policy and out-of-range protection. Optional macro: DPRAM_BYTE_MASK_EN.
module dual_port_ram_param #(
    parameter int                 DATA_W     = 8,
    parameter int                 ADDR_W     = 8,
    parameter int                 DEPTH      = 256,
    parameter int                 RD_LATENCY = 1,
    parameter int                 RDW_MODE   = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef DPRAM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] wr_be,
`endif
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

`ifdef DPRAM_BYTE_MASK_EN
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = 8;
`else
    localparam int LANES  = 1;
    localparam int LANE_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_reg;
    logic [ADDR_W-1:0] sweep_addr_reg;
    logic              busy_reg;

    logic              ready;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_in_range;
    logic              bypass_hit;
    logic [LANES-1:0]  port_lanes;
    logic [DATA_W-1:0] mem_rd_word;
    logic [DATA_W-1:0] rd_word_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_lanes;

    logic [DATA_W-1:0] rd_stage1_data_reg;
    logic              rd_stage1_valid_reg;

    assign ready       = (state_reg == ST_READY);
    assign wr_ok       = ready && wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_ok       = ready && rd_en;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign bypass_hit  = (RDW_MODE != 0) && wr_ok && (wr_addr == rd_addr);
    assign mem_rd_word = rd_in_range ? mem[rd_addr] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef DPRAM_BYTE_MASK_EN
            assign port_lanes[gi] = wr_be[gi];
`else
            assign port_lanes[gi] = 1'b1;
`endif
            // Bypass takes only the lanes actually being written this edge
            assign rd_word_next[gi*LANE_W +: LANE_W] = (bypass_hit && port_lanes[gi])
                ? wr_data[gi*LANE_W +: LANE_W]
                : mem_rd_word[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Single write port shared by the clear sweep and the user port
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_lanes = port_lanes;
        if (!rst) begin
            if (!ready) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_addr_reg;
                mem_wdata = INIT_VAL;
                mem_lanes = '1;
            end else begin
                mem_we = wr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lanes[i]) begin
                    mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            sweep_addr_reg <= '0;
            busy_reg       <= 1'b1;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_addr_reg <= sweep_addr_reg + 1'b1;
                    if (sweep_addr_reg == LAST_ADDR) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_READY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stage1_valid_reg <= 1'b0;
            rd_stage1_data_reg  <= '0;
        end else begin
            rd_stage1_valid_reg <= rd_ok;
            if (rd_ok) begin
                rd_stage1_data_reg <= rd_word_next;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_stage2_data_reg;
            logic              rd_stage2_valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_stage2_valid_reg <= 1'b0;
                    rd_stage2_data_reg  <= '0;
                end else begin
                    rd_stage2_valid_reg <= rd_stage1_valid_reg;
                    if (rd_stage1_valid_reg) begin
                        rd_stage2_data_reg <= rd_stage1_data_reg;
                    end
                end
            end

            assign rd_data  = rd_stage2_data_reg;
            assign rd_valid = rd_stage2_valid_reg;
        end else begin : g_lat1
            assign rd_data  = rd_stage1_data_reg;
            assign rd_valid = rd_stage1_valid_reg;
        end
    endgenerate

    assign busy = busy_reg;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: instance A uses default parameters, instance B uses DEPTH=200,
// RD_LATENCY=2, RDW_MODE=1, INIT_VAL=0xFF.
module tb_dual_port_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       a_rst = 1'b1, a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic [7:0] a_wr_addr = '0, a_wr_data = '0, a_rd_addr = '0;
    logic [7:0] a_rd_data;
    logic       a_rd_valid, a_busy;

    logic       b_rst = 1'b1, b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic [7:0] b_wr_addr = '0, b_wr_data = '0, b_rd_addr = '0;
    logic [7:0] b_rd_data;
    logic       b_rd_valid, b_busy;

`ifdef DPRAM_BYTE_MASK_EN
    logic [0:0] a_wr_be = 1'b1;
    logic [0:0] b_wr_be = 1'b1;
`endif

    dual_port_ram_param u_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
`ifdef DPRAM_BYTE_MASK_EN
        .wr_be(a_wr_be),
`endif
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .busy(a_busy)
    );

    dual_port_ram_param #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(2), .RDW_MODE(1), .INIT_VAL(8'hFF)
    ) u_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
`ifdef DPRAM_BYTE_MASK_EN
        .wr_be(b_wr_be),
`endif
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [7:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
        $display("A wr addr=%02h data=%02h", addr, data);
    endtask

    task automatic a_read(input logic [7:0] addr, output logic [7:0] data, output logic valid);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        data = a_rd_data; valid = a_rd_valid;
        $display("A rd addr=%02h data=%02h valid=%0b", addr, data, valid);
    endtask

    task automatic b_write(input logic [7:0] addr, input logic [7:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
        tick();
        b_wr_en = 1'b0;
        $display("B wr addr=%02h data=%02h", addr, data);
    endtask

    task automatic b_read(input logic [7:0] addr, output logic [7:0] data, output logic valid);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        tick();
        data = b_rd_data; valid = b_rd_valid;
        $display("B rd addr=%02h data=%02h valid=%0b", addr, data, valid);
    endtask

    task automatic test_reset();
        int n = 0;
        int pulses = 0;
        a_rst = 1'b1; a_rd_en = 1'b1; a_rd_addr = 8'h00;
        repeat (3) tick();
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", a_busy); end
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_rd_valid); end
        checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", a_rd_data); end
        a_rst = 1'b0;
        while (a_busy === 1'b1 && n < 400) begin
            tick();
            n++;
            if (a_rd_valid !== 1'b0) pulses++;
        end
        a_rd_en = 1'b0;
        tick();
        if (a_rd_valid !== 1'b0) pulses++;
        $display("A sweep busy_cycles=%0d valid_pulses=%0d", n, pulses);
        checks++; if (n != 256) begin failures++; $display("FAIL busy_len got=%0d exp=256", n); end
        checks++; if (pulses != 0) begin failures++; $display("FAIL busy_reads got=%0d exp=0", pulses); end
    endtask

    task automatic test_read_all();
        for (int i = 0; i < 256; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 8'(i);
            tick();
            $display("A rd addr=%02h data=%02h valid=%0b", i, a_rd_data, a_rd_valid);
            checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                failures++;
                $display("FAIL read_all[%02h] got valid=%b data=%02h exp valid=1 data=00", i, a_rd_valid, a_rd_data);
            end
        end
        a_rd_en = 1'b0;
        tick();
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL read_all_end valid got=%b exp=0", a_rd_valid); end
    endtask

    task automatic test_write_read();
        a_write(8'h10, 8'hA5);
        a_write(8'hFF, 8'h3C);
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL wr_no_valid got=%b exp=0", a_rd_valid); end
        a_rd_en = 1'b1; a_rd_addr = 8'h10;
        tick();
        $display("A rd addr=10 data=%02h valid=%0b", a_rd_data, a_rd_valid);
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5) begin
            failures++; $display("FAIL b2b_first got valid=%b data=%02h exp valid=1 data=a5", a_rd_valid, a_rd_data);
        end
        a_rd_addr = 8'hFF;
        tick();
        a_rd_en = 1'b0;
        $display("A rd addr=ff data=%02h valid=%0b", a_rd_data, a_rd_valid);
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h3C) begin
            failures++; $display("FAIL b2b_second got valid=%b data=%02h exp valid=1 data=3c", a_rd_valid, a_rd_data);
        end
        tick();
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h3C) begin
            failures++; $display("FAIL hold got valid=%b data=%02h exp valid=0 data=3c", a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_rdw();
        logic [7:0] d;
        logic       v;
        a_write(8'h20, 8'h11);
        a_wr_en = 1'b1; a_wr_addr = 8'h20; a_wr_data = 8'h22;
        a_rd_en = 1'b1; a_rd_addr = 8'h20;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        $display("A rdw addr=20 data=%02h valid=%0b", a_rd_data, a_rd_valid);
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h11) begin
            failures++; $display("FAIL rdw_old got valid=%b data=%02h exp valid=1 data=11", a_rd_valid, a_rd_data);
        end
        a_read(8'h20, d, v);
        checks++; if (d !== 8'h22 || v !== 1'b1) begin failures++; $display("FAIL rdw_after got=%02h exp=22", d); end
    endtask

    task automatic test_diff_addr();
        logic [7:0] d;
        logic       v;
        a_wr_en = 1'b1; a_wr_addr = 8'h30; a_wr_data = 8'h99;
        a_rd_en = 1'b1; a_rd_addr = 8'h10;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        $display("A wr addr=30 data=99 / rd addr=10 data=%02h", a_rd_data);
        checks++; if (a_rd_data !== 8'hA5) begin failures++; $display("FAIL diff_addr_rd got=%02h exp=a5", a_rd_data); end
        a_read(8'h30, d, v);
        checks++; if (d !== 8'h99) begin failures++; $display("FAIL diff_addr_wr got=%02h exp=99", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       v;
        int n = 0;
        a_write(8'h05, 8'h5A);
        a_read(8'h05, d, v);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL pre_reset got=%02h exp=5a", d); end
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        repeat (50) tick();
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL mid_sweep_busy got=%b exp=1", a_busy); end
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        while (a_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        $display("A re-sweep busy_cycles=%0d", n);
        checks++; if (n != 256) begin failures++; $display("FAIL resweep_len got=%0d exp=256", n); end
        a_read(8'h05, d, v);
        checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL post_reset got=%02h exp=00", d); end
    endtask

    task automatic test_b_reset();
        int n = 0;
        b_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (b_busy !== 1'b1 || b_rd_valid !== 1'b0 || b_rd_data !== 8'h00) begin
            failures++; $display("FAIL b_reset got busy=%b valid=%b data=%02h exp 1 0 00", b_busy, b_rd_valid, b_rd_data);
        end
        b_rst = 1'b0;
        while (b_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        $display("B sweep busy_cycles=%0d", n);
        checks++; if (n != 200) begin failures++; $display("FAIL b_busy_len got=%0d exp=200", n); end
    endtask

    task automatic test_b_latency();
        b_write(8'h10, 8'hA5);
        b_write(8'h50, 8'h3C);
        b_rd_en = 1'b1; b_rd_addr = 8'h10;
        tick();
        checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL b_lat_early got=%b exp=0", b_rd_valid); end
        b_rd_addr = 8'h50;
        tick();
        b_rd_en = 1'b0;
        $display("B rd addr=10 data=%02h valid=%0b", b_rd_data, b_rd_valid);
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hA5) begin
            failures++; $display("FAIL b_lat_first got valid=%b data=%02h exp valid=1 data=a5", b_rd_valid, b_rd_data);
        end
        tick();
        $display("B rd addr=50 data=%02h valid=%0b", b_rd_data, b_rd_valid);
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h3C) begin
            failures++; $display("FAIL b_lat_second got valid=%b data=%02h exp valid=1 data=3c", b_rd_valid, b_rd_data);
        end
        tick();
        checks++;
        if (b_rd_valid !== 1'b0 || b_rd_data !== 8'h3C) begin
            failures++; $display("FAIL b_hold got valid=%b data=%02h exp valid=0 data=3c", b_rd_valid, b_rd_data);
        end
    endtask

    task automatic test_b_range();
        logic [7:0] d;
        logic       v;
        b_write(8'hC8, 8'h77);
        b_read(8'hC8, d, v);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL b_oor got valid=%b data=%02h exp valid=1 data=00", v, d); end
        b_read(8'h00, d, v);
        checks++; if (d !== 8'hFF) begin failures++; $display("FAIL b_addr0 got=%02h exp=ff", d); end
        b_write(8'hC7, 8'h42);
        b_read(8'hC7, d, v);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL b_last_addr got=%02h exp=42", d); end
        b_read(8'h05, d, v);
        checks++; if (d !== 8'hFF) begin failures++; $display("FAIL b_init_val got=%02h exp=ff", d); end
    endtask

    task automatic test_b_rdw();
        logic [7:0] d;
        logic       v;
        b_write(8'h20, 8'h11);
        b_wr_en = 1'b1; b_wr_addr = 8'h20; b_wr_data = 8'h22;
        b_rd_en = 1'b1; b_rd_addr = 8'h20;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        tick();
        $display("B rdw addr=20 data=%02h valid=%0b", b_rd_data, b_rd_valid);
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h22) begin
            failures++; $display("FAIL b_rdw_new got valid=%b data=%02h exp valid=1 data=22", b_rd_valid, b_rd_data);
        end
        b_read(8'h20, d, v);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL b_rdw_after got=%02h exp=22", d); end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_write_read();
        test_rdw();
        test_diff_addr();
        test_reset_mid();
        test_b_reset();
        test_b_latency();
        test_b_range();
        test_b_rdw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
